branch_target_predictor: RTL and testbench

- Parametrised successor to the CPU's fixed branch prediction table.
- Direct-mapped branch target buffer with per-entry 2-bit saturating counters, configurable entry count and tag handling, and bulk invalidate.
- Sits in IF: it predicts taken/target for the fetch PC. ID resolution writes back the actual outcome.

---
 rtl/branch_target_predictor.sv | 112 +++++++++++
 tb/tb_branch_target_predictor.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional statistics counters enabled by defining BTP_STATS_EN.
module branch_target_predictor #(
  parameter int         DATA_W   = 64,
  parameter int         ENTRIES  = 16,
  parameter int         TAG_W    = DATA_W - $clog2(ENTRIES) - 2,
  parameter logic [1:0] CNT_INIT = 2'b10,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              inv,
  input  logic [DATA_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [DATA_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              upd_mispredict
`ifdef BTP_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TLO   = IDX_W + 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             accept;
  logic             unused_ok;

  // Low PC bits and aliased upper bits are deliberately ignored.
  assign unused_ok = ^{lk_pc, upd_pc, upd_mispredict};

  assign lk_idx = lk_pc[TLO-1:2];
  assign lk_tag = lk_pc[TLO+TAG_W-1:TLO];
  assign u_idx  = upd_pc[TLO-1:2];
  assign u_tag  = upd_pc[TLO+TAG_W-1:TLO];

  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && cnt_q[lk_idx][1];
  assign lk_target = lk_hit ? target_q[lk_idx] : '0;

  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign accept = enable && upd_valid && !inv;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b00;
      end
    end else if (enable && inv) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (accept) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (cnt_q[u_idx] != 2'b11) begin
            cnt_q[u_idx] <= cnt_q[u_idx] + 2'b01;
          end
        end else if (cnt_q[u_idx] != 2'b00) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        cnt_q[u_idx]    <= CNT_INIT;
      end
    end
  end

`ifdef BTP_STATS_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (enable && stat_clear) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (stat_updates != '1) begin
        stat_updates <= stat_updates + 1'b1;
      end
      if (upd_mispredict && stat_mispredicts != '1) begin
        stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor.
// Stats scenario runs only when BTP_STATS_EN is defined.
module tb_branch_target_predictor;

  logic        clk;
  logic        arst;
  logic        enable;
  logic        inv;
  logic [63:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [63:0] lk_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
`ifdef BTP_STATS_EN
  logic        stat_clear;
  logic [1:0]  stat_updates;
  logic [1:0]  stat_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  branch_target_predictor #(
    .DATA_W(64),
    .ENTRIES(16),
    .STAT_W(2)
  ) dut (
    .clk(clk),
    .arst(arst),
    .enable(enable),
    .inv(inv),
    .lk_pc(lk_pc),
    .lk_hit(lk_hit),
    .lk_taken(lk_taken),
    .lk_target(lk_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_target(upd_target),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict)
`ifdef BTP_STATS_EN
    ,
    .stat_clear(stat_clear),
    .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One update cycle; returns at posedge + 1.
  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt,
                     input logic tk, input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_taken      = tk;
    upd_mispredict = mp;
    @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic test_reset;
    lk_pc = 64'h100;
    #3;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL reset_out got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL post_reset got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alloc;
    upd(64'h100, 64'h200, 1'b1, 1'b0);
    lk_pc = 64'h100;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h200}) begin
      errors++;
      $display("FAIL alloc_hit got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h200});
    end
    lk_pc = 64'h104;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL alloc_neighbour got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
  endtask

  task automatic test_saturation;
    upd(64'h100, 64'h900, 1'b0, 1'b0);
    lk_pc = 64'h100;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b10, 64'h200}) begin
      errors++;
      $display("FAIL sat_cnt1 got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b10, 64'h200});
    end
    upd(64'h100, 64'h900, 1'b0, 1'b0);
    upd(64'h100, 64'h900, 1'b0, 1'b0);
    // Floor at 0: one taken update must only reach 1 (not taken).
    upd(64'h100, 64'h200, 1'b1, 1'b0);
    lk_pc = 64'h100;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b10, 64'h200}) begin
      errors++;
      $display("FAIL sat_floor got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b10, 64'h200});
    end
    upd(64'h100, 64'h200, 1'b1, 1'b0);
    upd(64'h100, 64'h200, 1'b1, 1'b0);
    upd(64'h100, 64'h280, 1'b1, 1'b0);
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h280}) begin
      errors++;
      $display("FAIL sat_cnt3 got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h280});
    end
    upd(64'h100, 64'h900, 1'b0, 1'b0);
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h280}) begin
      errors++;
      $display("FAIL sat_ceiling got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h280});
    end
  endtask

  task automatic test_alias;
    upd(64'h140, 64'h300, 1'b1, 1'b0);
    lk_pc = 64'h100;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL alias_old got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
    lk_pc = 64'h140;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h300}) begin
      errors++;
      $display("FAIL alias_new got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h300});
    end
    upd(64'h180, 64'h400, 1'b0, 1'b0);
    lk_pc = 64'h140;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h300}) begin
      errors++;
      $display("FAIL alias_keep got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h300});
    end
    lk_pc = 64'h180;
    #1;
    checks++;
    if (lk_hit !== 1'b0) begin
      errors++;
      $display("FAIL alias_nt_miss got=%0b exp=0", lk_hit);
    end
  endtask

  task automatic test_collision;
    lk_pc      = 64'h140;
    upd_valid  = 1'b1;
    upd_pc     = 64'h140;
    upd_target = 64'h500;
    upd_taken  = 1'b1;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h300}) begin
      errors++;
      $display("FAIL coll_old got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h300});
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h500}) begin
      errors++;
      $display("FAIL coll_new got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h500});
    end
  endtask

  task automatic test_inv;
    inv = 1'b1;
    upd(64'h204, 64'h600, 1'b1, 1'b0);
    inv = 1'b0;
    lk_pc = 64'h140;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL inv_clear got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
    lk_pc = 64'h204;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL inv_drop got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
  endtask

  task automatic test_enable;
    upd(64'h140, 64'h700, 1'b1, 1'b0);
    enable = 1'b0;
    inv    = 1'b1;
    upd(64'h140, 64'h900, 1'b0, 1'b0);
    upd(64'h144, 64'h800, 1'b1, 1'b0);
    inv = 1'b0;
    lk_pc = 64'h140;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'h700}) begin
      errors++;
      $display("FAIL en_hold got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'h700});
    end
    lk_pc = 64'h144;
    #1;
    checks++;
    if (lk_hit !== 1'b0) begin
      errors++;
      $display("FAIL en_noalloc got=%0b exp=0", lk_hit);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    upd(64'h100, 64'hA00, 1'b1, 1'b0);
    upd(64'h204, 64'hB00, 1'b1, 1'b0);
    upd(64'h308, 64'hC00, 1'b1, 1'b0);
    lk_pc = 64'h204;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== {2'b11, 64'hB00}) begin
      errors++;
      $display("FAIL rst_pre got=%0h exp=%0h",
               {lk_hit, lk_taken, lk_target}, {2'b11, 64'hB00});
    end
    #1;
    arst = 1'b1;
    #1;
    checks++;
    if ({lk_hit, lk_taken, lk_target} !== 66'h0) begin
      errors++;
      $display("FAIL rst_async got=%0h exp=0", {lk_hit, lk_taken, lk_target});
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    lk_pc = 64'h100;
    #1;
    checks++;
    if (lk_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_miss100 got=%0b exp=0", lk_hit);
    end
    lk_pc = 64'h308;
    #1;
    checks++;
    if ({lk_hit, lk_target} !== 65'h0) begin
      errors++;
      $display("FAIL rst_miss308 got=%0h exp=0", {lk_hit, lk_target});
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BTP_STATS_EN
  task automatic test_stats;
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    checks++;
    if ({stat_updates, stat_mispredicts} !== 4'b0000) begin
      errors++;
      $display("FAIL stat_clear0 got=%0h exp=0", {stat_updates, stat_mispredicts});
    end
    upd(64'h400, 64'h10, 1'b1, 1'b1);
    upd(64'h404, 64'h10, 1'b0, 1'b0);
    upd(64'h408, 64'h10, 1'b1, 1'b1);
    upd(64'h40C, 64'h10, 1'b0, 1'b0);
    upd(64'h410, 64'h10, 1'b1, 1'b0);
    checks++;
    if ({stat_updates, stat_mispredicts} !== {2'd3, 2'd2}) begin
      errors++;
      $display("FAIL stat_count got=%0h exp=%0h",
               {stat_updates, stat_mispredicts}, {2'd3, 2'd2});
    end
    stat_clear = 1'b1;
    upd(64'h414, 64'h10, 1'b1, 1'b1);
    stat_clear = 1'b0;
    checks++;
    if ({stat_updates, stat_mispredicts} !== 4'b0000) begin
      errors++;
      $display("FAIL stat_clear got=%0h exp=0", {stat_updates, stat_mispredicts});
    end
  endtask
`endif

  initial begin
    arst           = 1'b1;
    enable         = 1'b1;
    inv            = 1'b0;
    lk_pc          = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
`ifdef BTP_STATS_EN
    stat_clear     = 1'b0;
`endif
    test_reset;
    test_alloc;
    test_saturation;
    test_alias;
    test_collision;
    test_inv;
    test_enable;
    test_reset_mid;
`ifdef BTP_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
